stage_decoder: RTL and testbench

- Receiving end of the 6-stage one-hot stage vector produced by StageClock.
- Samples the vector on every shift edge and checks that it is legally one-hot and advances only 0,1,...,N-1,0.
- Produces an encoded stage index, per-stage entry pulses, a round-complete pulse and a saturating round counter.
- Flags any protocol violation with a sticky error, so downstream pipeline stages can act on stage entry without decoding the raw vector themselves.

---
 rtl/stage_decoder_if.sv | 27 ++
 rtl/stage_decoder.sv | 109 ++++++++++
 tb/tb_stage_decoder.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/stage_decoder_if.sv
// rtl/stage_decoder_if.sv - stage vector input and decoded stage outputs bundle
interface stage_decoder_if #(
  parameter int NSTAGES = 6,
  parameter int IDX_W   = 3,
  parameter int CNT_W   = 8
);
  logic [NSTAGES-1:0] stage_in;
  logic               clr_err;
  logic [IDX_W-1:0]   stage_idx;
  logic               stage_valid;
  logic [NSTAGES-1:0] stage_pulse;
  logic               round_done;
  logic [CNT_W-1:0]   round_count;
  logic               err;

  // Sequencer/controller side: drives the raw vector and the error clear
  modport master (
    output stage_in, clr_err,
    input  stage_idx, stage_valid, stage_pulse, round_done, round_count, err
  );

  // Decoder side
  modport slave (
    input  stage_in, clr_err,
    output stage_idx, stage_valid, stage_pulse, round_done, round_count, err
  );
endinterface

// File: rtl/stage_decoder.sv
// rtl/stage_decoder.sv - one-hot stage vector checker and decoder
module stage_decoder #(
  parameter int NSTAGES = 6,
  parameter int IDX_W   = 3,
  parameter int CNT_W   = 8
) (
  input logic              shift,
  input logic              rst,
  stage_decoder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, TRACK, ERROR} state_t;

  localparam logic [NSTAGES-1:0] FIRST_VEC = NSTAGES'(1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NSTAGES - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NSTAGES-1:0] pulse_q, pulse_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               wrap;
  logic [IDX_W-1:0]   nxt_idx;
  logic [NSTAGES-1:0] cur_vec;
  logic [NSTAGES-1:0] nxt_vec;
  logic               multi_hot;

  // Expected vectors for "hold" and "advance" relative to the tracked stage
  always_comb begin
    wrap      = (idx_q == LAST_IDX);
    nxt_idx   = wrap ? '0 : idx_q + 1'b1;
    cur_vec   = FIRST_VEC << idx_q;
    nxt_vec   = FIRST_VEC << nxt_idx;
    // Clearing the lowest set bit leaves something only if two or more were set
    multi_hot = (bus.stage_in & (bus.stage_in - FIRST_VEC)) != '0;
  end

  // Next-state and next-output decision for the protocol checker
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pulse_d = '0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // Only a clean bit0 starts tracking, so a mid-round attach waits quietly
        if (bus.stage_in == FIRST_VEC) begin
          state_d = TRACK;
          idx_d   = '0;
          pulse_d = FIRST_VEC;
        end else if (multi_hot) begin
          state_d = ERROR;
        end
      end
      TRACK: begin
        if (bus.stage_in == cur_vec) begin
          state_d = TRACK;
        end else if (bus.stage_in == nxt_vec) begin
          idx_d   = nxt_idx;
          pulse_d = nxt_vec;
          if (wrap) begin
            done_d = 1'b1;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end else if (bus.stage_in == '0) begin
          // Sequencer stopped; remember where it was
          state_d = IDLE;
        end else begin
          state_d = ERROR;
        end
      end
      ERROR: begin
        if (bus.clr_err) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset wipes everything including the round count
  always_ff @(posedge shift) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pulse_q <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stage_idx   = idx_q;
  assign bus.stage_valid = (state_q == TRACK);
  assign bus.stage_pulse = pulse_q;
  assign bus.round_done  = done_q;
  assign bus.round_count = cnt_q;
  assign bus.err         = (state_q == ERROR);

endmodule

// File: tb/tb_stage_decoder.sv
// tb/tb_stage_decoder.sv - self-checking bench for stage_decoder
module tb_stage_decoder;

  localparam int N = 6;

  logic shift;
  logic rst;

  stage_decoder_if #(.NSTAGES(N), .IDX_W(3), .CNT_W(8)) b8 ();
  stage_decoder_if #(.NSTAGES(N), .IDX_W(3), .CNT_W(2)) b2 ();

  stage_decoder #(.NSTAGES(N), .IDX_W(3), .CNT_W(8)) dut8 (.shift(shift), .rst(rst), .bus(b8));
  stage_decoder #(.NSTAGES(N), .IDX_W(3), .CNT_W(2)) dut2 (.shift(shift), .rst(rst), .bus(b2));

  initial shift = 1'b0;
  always #5 shift = ~shift;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = waiting for sync, 1 = following the sequence, 2 = faulted
  int       m_mode;
  int       m_idx;
  logic [5:0] m_pulse;
  logic     m_done;
  int       m_cnt8;
  int       m_cnt2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic c, input logic [5:0] in);
    int nxt;
    m_pulse = '0;
    m_done  = 1'b0;
    if (r) begin
      m_mode = 0; m_idx = 0; m_cnt8 = 0; m_cnt2 = 0;
    end else if (m_mode == 0) begin
      if (in == 6'd1) begin
        m_mode = 1; m_idx = 0; m_pulse = 6'd1;
      end else if ($countones(in) > 1) begin
        m_mode = 2;
      end
    end else if (m_mode == 1) begin
      nxt = (m_idx + 1) % N;
      if (in == 6'(1 << m_idx)) begin
        m_mode = 1;
      end else if (in == 6'(1 << nxt)) begin
        m_idx   = nxt;
        m_pulse = 6'(1 << nxt);
        if (nxt == 0) begin
          m_done = 1'b1;
          if (m_cnt8 < 255) m_cnt8++;
          if (m_cnt2 < 3) m_cnt2++;
        end
      end else if (in == 6'd0) begin
        m_mode = 0;
      end else begin
        m_mode = 2;
      end
    end else begin
      if (c) m_mode = 0;
    end
  endtask

  task automatic compare_model();
    chk("m8_idx",   32'(b8.stage_idx),   32'(m_idx));
    chk("m8_valid", 32'(b8.stage_valid), 32'(m_mode == 1));
    chk("m8_pulse", 32'(b8.stage_pulse), 32'(m_pulse));
    chk("m8_done",  32'(b8.round_done),  32'(m_done));
    chk("m8_cnt",   32'(b8.round_count), 32'(m_cnt8));
    chk("m8_err",   32'(b8.err),         32'(m_mode == 2));
    chk("m2_idx",   32'(b2.stage_idx),   32'(m_idx));
    chk("m2_cnt",   32'(b2.round_count), 32'(m_cnt2));
    chk("m2_err",   32'(b2.err),         32'(m_mode == 2));
  endtask

  task automatic step(input logic r, input logic c, input logic [5:0] in);
    rst = r;
    b8.stage_in = in; b8.clr_err = c;
    b2.stage_in = in; b2.clr_err = c;
    @(posedge shift);
    #1;
    model_update(r, c, in);
    compare_model();
  endtask

  typedef struct {
    logic       r;
    logic       c;
    logic [5:0] in;
    int         idx;
    logic       v;
    logic [5:0] p;
    logic       d;
    int         cnt;
    logic       e;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic c, logic [5:0] in, int idx, logic v,
                              logic [5:0] p, logic d, int cnt, logic e);
    vec_t t;
    t.r = r; t.c = c; t.in = in; t.idx = idx; t.v = v;
    t.p = p; t.d = d; t.cnt = cnt; t.e = e;
    return t;
  endfunction

  task automatic walk_round();
    for (int s = 1; s <= N; s++) step(1'b0, 1'b0, 6'(1 << (s % N)));
  endtask

  initial begin
    int nd;
    int r;
    logic [5:0] in;
    logic c;
    logic rr;
    int exp2[5];

    rst = 1'b1;
    b8.stage_in = '0; b8.clr_err = 1'b0;
    b2.stage_in = '0; b2.clr_err = 1'b0;
    m_mode = 0; m_idx = 0; m_pulse = '0; m_done = 1'b0; m_cnt8 = 0; m_cnt2 = 0;

    //             r  c  in          idx v  pulse      d  cnt e
    tbl.push_back(mk(1, 0, 6'b000001, 0, 0, 6'b000000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 6'b000001, 0, 0, 6'b000000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 6'b000001, 0, 1, 6'b000001, 0, 0, 0));
    tbl.push_back(mk(0, 0, 6'b000010, 1, 1, 6'b000010, 0, 0, 0));
    tbl.push_back(mk(0, 0, 6'b000100, 2, 1, 6'b000100, 0, 0, 0));
    tbl.push_back(mk(0, 0, 6'b001000, 3, 1, 6'b001000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 6'b010000, 4, 1, 6'b010000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 6'b100000, 5, 1, 6'b100000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 6'b000001, 0, 1, 6'b000001, 1, 1, 0));
    tbl.push_back(mk(0, 0, 6'b000010, 1, 1, 6'b000010, 0, 1, 0));
    tbl.push_back(mk(0, 0, 6'b000100, 2, 1, 6'b000100, 0, 1, 0));
    tbl.push_back(mk(0, 0, 6'b000100, 2, 1, 6'b000000, 0, 1, 0));
    tbl.push_back(mk(0, 0, 6'b000100, 2, 1, 6'b000000, 0, 1, 0));
    tbl.push_back(mk(0, 0, 6'b000100, 2, 1, 6'b000000, 0, 1, 0));
    tbl.push_back(mk(0, 0, 6'b000000, 2, 0, 6'b000000, 0, 1, 0));
    tbl.push_back(mk(0, 0, 6'b000001, 0, 1, 6'b000001, 0, 1, 0));
    tbl.push_back(mk(0, 0, 6'b000010, 1, 1, 6'b000010, 0, 1, 0));
    tbl.push_back(mk(0, 0, 6'b001001, 1, 0, 6'b000000, 0, 1, 1));
    tbl.push_back(mk(0, 0, 6'b000100, 1, 0, 6'b000000, 0, 1, 1));
    tbl.push_back(mk(0, 0, 6'b000001, 1, 0, 6'b000000, 0, 1, 1));
    tbl.push_back(mk(0, 1, 6'b000000, 1, 0, 6'b000000, 0, 1, 0));
    tbl.push_back(mk(0, 0, 6'b000001, 0, 1, 6'b000001, 0, 1, 0));
    tbl.push_back(mk(0, 0, 6'b000010, 1, 1, 6'b000010, 0, 1, 0));
    tbl.push_back(mk(0, 0, 6'b001000, 1, 0, 6'b000000, 0, 1, 1));
    tbl.push_back(mk(0, 1, 6'b000001, 1, 0, 6'b000000, 0, 1, 0));
    tbl.push_back(mk(0, 0, 6'b000001, 0, 1, 6'b000001, 0, 1, 0));
    tbl.push_back(mk(0, 1, 6'b000010, 1, 1, 6'b000010, 0, 1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].c, tbl[i].in);
      chk($sformatf("t%0d_idx", i),   32'(b8.stage_idx),   32'(tbl[i].idx));
      chk($sformatf("t%0d_valid", i), 32'(b8.stage_valid), 32'(tbl[i].v));
      chk($sformatf("t%0d_pulse", i), 32'(b8.stage_pulse), 32'(tbl[i].p));
      chk($sformatf("t%0d_done", i),  32'(b8.round_done),  32'(tbl[i].d));
      chk($sformatf("t%0d_cnt", i),   32'(b8.round_count), 32'(tbl[i].cnt));
      chk($sformatf("t%0d_err", i),   32'(b8.err),         32'(tbl[i].e));
    end

    // Saturation on the narrow counter: five rounds read 1,2,3,3,3
    exp2[0] = 1; exp2[1] = 2; exp2[2] = 3; exp2[3] = 3; exp2[4] = 3;
    step(1'b1, 1'b0, 6'b000001);
    step(1'b0, 1'b0, 6'b000001);
    nd = 0;
    for (int k = 0; k < 5; k++) begin
      for (int s = 1; s <= N; s++) begin
        step(1'b0, 1'b0, 6'(1 << (s % N)));
        if (b2.round_done === 1'b1) nd++;
      end
      chk($sformatf("sat_cnt%0d", k), 32'(b2.round_count), 32'(exp2[k]));
    end
    chk("sat_ndone", 32'(nd), 32'd5);
    chk("wide_cnt5", 32'(b8.round_count), 32'd5);

    // Reset together with clr_err mid-round at stage 3 with two rounds done
    step(1'b1, 1'b0, 6'b000001);
    step(1'b0, 1'b0, 6'b000001);
    walk_round();
    walk_round();
    step(1'b0, 1'b0, 6'b000010);
    step(1'b0, 1'b0, 6'b000100);
    step(1'b0, 1'b0, 6'b001000);
    chk("mid_idx", 32'(b8.stage_idx), 32'd3);
    chk("mid_cnt", 32'(b8.round_count), 32'd2);
    step(1'b1, 1'b1, 6'b010000);
    chk("rst_all", {b8.stage_idx, b8.stage_valid, b8.stage_pulse, b8.round_done,
                    b8.round_count, b8.err}, 32'd0);
    step(1'b0, 1'b0, 6'b000100);
    chk("resync_valid", 32'(b8.stage_valid), 32'd0);
    chk("resync_err", 32'(b8.err), 32'd0);
    step(1'b0, 1'b0, 6'b001000);
    chk("resync_valid2", 32'(b8.stage_valid), 32'd0);
    step(1'b0, 1'b0, 6'b000001);
    chk("resync_go", {b8.stage_valid, b8.stage_pulse}, {1'b1, 6'b000001});

    // Randomised traffic, biased toward legal advances so rounds actually complete
    for (int k = 0; k < 3000; k++) begin
      r  = $urandom_range(0, 99);
      rr = ($urandom_range(0, 199) == 0);
      c  = ($urandom_range(0, 9) == 0);
      if (r < 60)      in = (m_mode == 1) ? 6'(1 << ((m_idx + 1) % N)) : 6'd1;
      else if (r < 75) in = 6'(1 << m_idx);
      else if (r < 80) in = 6'd0;
      else if (r < 92) in = 6'($urandom_range(0, 63));
      else             in = 6'(1 << $urandom_range(0, N - 1));
      step(rr, c, in);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
